// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } uart_state_e;

    localparam int unsigned UART_CLKS_PER_BIT = 55;
    localparam int unsigned UART_DATA_BITS    = 8;
    localparam logic        UART_IDLE_LEVEL   = 1'b1;

    typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line status bundle between a byte source and uart_tx.
interface uart_tx_if;
    import uart_pkg::*;

    uart_byte_t tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;
    logic       tx_done;

    modport master (output tx_byte, tx_valid, input tx_ready, tx_out, tx_busy, tx_done);
    modport slave  (input tx_byte, tx_valid, output tx_ready, tx_out, tx_busy, tx_done);
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that parks at zero; tc_c_o flags the terminal count.
module uart_bit_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_c_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_c_o  = (count_q == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter with a one-byte holding register for back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned DELAY          = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);

    localparam int unsigned STOP_CLKS = STOP_BITS * CLOCKS_PER_BIT;
    localparam int unsigned MAX_CNT   = (STOP_CLKS > DELAY) ? STOP_CLKS : DELAY;
    localparam int unsigned CNT_W     = $clog2(MAX_CNT);
    localparam int unsigned IDX_W     = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD  = CNT_W'(STOP_CLKS - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY - 1);
    localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(UART_DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    uart_byte_t       shift_q, shift_d;
    uart_byte_t       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             tx_out_q, tx_out_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_tc;

    uart_bit_timer #(.WIDTH(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .count_o    (tmr_count),
        .tc_c_o     (tmr_tc)
    );

    // Next-state: byte acceptance into hold, then frame sequencing.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_idx_d   = bit_idx_q;
        tx_out_d    = tx_out_q;
        tx_done_d   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = BIT_LOAD;

        if (bus.tx_valid && !hold_full_q) begin
            hold_d      = bus.tx_byte;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_out_d = UART_IDLE_LEVEL;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    bit_idx_d   = '0;
                    tx_out_d    = 1'b0;
                    tmr_load    = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (tmr_tc) begin
                    tx_out_d = shift_q[0];
                    shift_d  = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    tmr_load = 1'b1;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        tx_out_d = UART_IDLE_LEVEL;
                        tmr_val  = STOP_LOAD;
                        state_d  = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_out_d  = shift_q[0];
                        shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    end
                end
            end
            ST_STOP: begin
                if (tmr_tc) begin
                    tmr_load  = 1'b1;
                    tmr_val   = DELAY_LOAD;
                    tx_done_d = (DELAY == 1);
                    state_d   = ST_CLEANUP;
                end
            end
            ST_CLEANUP: begin
                // tx_done is registered, so raise it one cycle ahead of the final guard cycle
                if (tmr_count == CNT_W'(1)) begin
                    tx_done_d = 1'b1;
                end
                if (tmr_tc) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        bit_idx_d   = '0;
                        tx_out_d    = 1'b0;
                        tmr_load    = 1'b1;
                        state_d     = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_out_d = UART_IDLE_LEVEL;
                state_d  = ST_IDLE;
            end
        endcase

        tx_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            tx_out_q    <= UART_IDLE_LEVEL;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_idx_q   <= bit_idx_d;
            tx_out_q    <= tx_out_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign bus.tx_ready = !hold_full_q;
    assign bus.tx_out   = tx_out_q;
    assign bus.tx_busy  = tx_busy_q;
    assign bus.tx_done  = tx_done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 by default, LSB first, line idle-high. It is the transmit counterpart of the existing UART receiver.
- Sends processed (downsampled) image bytes from the processor back to the host PC over the same serial link.
- Includes a one-byte holding register, so the next byte can be accepted while the current frame is still shifting out.
- Bit timing matches the receiver: the same CLOCKS_PER_BIT at the same system clock.

Parameters:
- CLOCKS_PER_BIT, 55, clk cycles per serial bit (5209 gives 9600 baud at 50 MHz). Must be ≥ 2.
- STOP_BITS, 1, number of stop bits (1 or 2).
- DELAY, 1, idle-high guard cycles after the stop bit(s) before tx_done. Must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_byte  in  8  byte to send. Sampled only on accept.
- tx_valid  in  1  tx_byte is valid.
- tx_ready  out  1  holding register empty; a byte can be accepted.
- tx_out  out  1  serial line (registered).
- tx_busy  out  1  a frame is in progress (any state other than IDLE).
- tx_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (rst_n=0, asynchronous): tx_out=1, tx_ready=1, tx_busy=0, tx_done=0. State=IDLE; all counters, the shift register and the holding register are cleared. A frame in progress is abandoned and its byte is lost; the line returns high immediately.
- Accept: on a rising edge where tx_valid && tx_ready, tx_byte is written to the holding register and hold_full is set.
  - tx_ready = !hold_full, driven combinationally from the flag.
  - No accept is possible on the same edge where hold→shift transfer occurs, because hold is full at that point.
- State machine (3-bit): IDLE, START, DATA_TX, STOP, CLEANUP.
  - IDLE: tx_out=1. If hold_full: shift_reg←hold, hold_full←0, clock_count←0, bit_index←0, state→START. tx_out goes low on the same edge.
  - START: tx_out=0 for exactly CLOCKS_PER_BIT cycles. Then tx_out←shift_reg[0] and state→DATA_TX.
  - DATA_TX: each bit is held CLOCKS_PER_BIT cycles, bit_index 0..7, LSB first. After bit 7 completes: tx_out←1, state→STOP.
  - STOP: tx_out=1 for STOP_BITS*CLOCKS_PER_BIT cycles, then state→CLEANUP.
  - CLEANUP: tx_out=1 for DELAY cycles. On the final cycle, tx_done is pulsed for 1 cycle.
    - If hold_full: load hold into shift_reg, state→START; tx_out goes low on that edge.
    - Otherwise: state→IDLE.
- Latency:
  - With the machine IDLE, if accept happens at edge k, tx_out falls after edge k+1.
  - Frame length from tx_out falling to the tx_done cycle: (9+STOP_BITS)*CLOCKS_PER_BIT + DELAY cycles.
- Back-to-back: a byte accepted at any time during a frame starts its start bit immediately after the previous CLEANUP. There is no extra IDLE cycle between frames.
- tx_out, tx_done and tx_busy are registered; there are no glitches on tx_out.
- clock_count is wide enough for STOP_BITS*CLOCKS_PER_BIT−1 and compares against (N−1), matching the receiver's counting convention.
- tx_valid while tx_ready=0 is ignored. The source must hold tx_valid/tx_byte until accepted.

Decomposition:
- Shared package uart_pkg:
  - State encodings IDLE/START/DATA/STOP/CLEANUP, shared with the receiver.
  - Default CLOCKS_PER_BIT.
  - Frame constants (8 data bits, idle level 1).
- One natural sub-module, uart_bit_timer: a parameterized down-counter with load and a terminal-count pulse, reusable by the receiver later.
- The holding register and FSM stay in uart_tx.

Test Plan (CLOCKS_PER_BIT=4, STOP_BITS=1, DELAY=1 unless noted):
- Reset then idle for 20 cycles -> tx_out=1, tx_ready=1, tx_busy=0, tx_done never asserted.
- Send 0xA5 from IDLE -> line segments of 4 cycles each: 0,1,0,1,0,0,1,0,1,1 (start, data 1,0,1,0,0,1,0,1, stop). Then 1 guard cycle and a tx_done pulse exactly 41 cycles after tx_out falls.
- Send 0x3C, then present 0xFF during 0x3C's data bits -> 0xFF accepted at once (tx_ready drops to 0). 0xFF's start bit begins on the cycle after 0x3C's tx_done cycle. Two tx_done pulses, 41 cycles apart. A third byte is held off (tx_ready=0) until 0xFF is loaded.
- STOP_BITS=2, send 0x00 -> 9×4 low cycles, 8 high stop cycles, 1 guard cycle, then tx_done. Frame = 45 cycles.
- Assert rst_n=0 mid-DATA_TX of 0x81 -> tx_out=1 asynchronously (before the next edge). After release, tx_busy=0, tx_ready=1, no tx_done. A new 0x42 is transmitted correctly.
- Loopback: uart_tx → existing receiver with the same CLOCKS_PER_BIT, bytes 0x00, 0x55, 0xAA, 0xFF back-to-back -> the receiver reports identical bytes in order, with one rx_done per tx_done.
